// File: rtl/fetch_pc_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit_pkg
// Shared types and constants for the instruction-fetch PC unit.
//   fetch_state_e : fetch FSM state (FETCH / WAIT / KILL), 2-bit encoded
//   fetch_entry_t : one fetched instruction plus its fall-through address
//   align_pc()    : clears bits [1:0] of an address
// -----------------------------------------------------------------------------
package fetch_pc_unit_pkg;

   localparam logic [31:0] NOP_INSTR_C     = 32'h0000_0000;
   localparam logic [31:0] PC_INC_C        = 32'd4;
   localparam logic [31:0] RESET_PC_C      = 32'h0000_0000;
   localparam logic [31:0] PC_ALIGN_MASK_C = 32'hFFFF_FFFC;

   // FETCH : a new request may be issued this cycle
   // WAIT  : a request is outstanding and must be held until ack
   // KILL  : the outstanding request belongs to a wrong path; its data is dropped
   typedef enum logic [1:0] {
      FETCH = 2'b00,
      WAIT  = 2'b01,
      KILL  = 2'b10
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc4;
   } fetch_entry_t;

   function automatic logic [31:0] align_pc(input logic [31:0] addr);
      return addr & PC_ALIGN_MASK_C;
   endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// -----------------------------------------------------------------------------
// fetch_skid_buf
// One-entry holding buffer for an instruction that returned from memory while
// the pipeline was stalled.
//   clk_i    : clock
//   rst_ni   : synchronous active-low reset (empties the buffer)
//   load_i   : capture entry_i, buffer becomes full
//   drain_i  : buffer contents consumed, buffer becomes empty
//   clear_i  : discard contents (flush); wins over load_i and drain_i
//   entry_i  : {instr, pc4} to capture
//   full_o   : buffer holds a valid entry
//   entry_o  : buffered {instr, pc4}
// -----------------------------------------------------------------------------
module fetch_skid_buf
   import fetch_pc_unit_pkg::*;
(
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         load_i,
   input  logic         drain_i,
   input  logic         clear_i,
   input  fetch_entry_t entry_i,
   output logic         full_o,
   output fetch_entry_t entry_o
);

   logic         full_q;
   logic         full_d;
   fetch_entry_t entry_q;

   always_comb begin
      full_d = full_q;
      if (clear_i) begin
         full_d = 1'b0;
      end else if (load_i) begin
         full_d = 1'b1;
      end else if (drain_i) begin
         full_d = 1'b0;
      end
   end

   // NOTE: sequential state is always written with non-blocking assignments so
   // every register samples values from before the edge, independent of order.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         full_q <= 1'b0;
      end else begin
         full_q <= full_d;
      end
   end

   // NOTE: the payload has no reset; it is only observed while full_q is set,
   // so resetting it would add reset fan-out without changing behaviour.
   always_ff @(posedge clk_i) begin
      if (load_i && !clear_i) begin
         entry_q <= entry_i;
      end
   end

   assign full_o  = full_q;
   assign entry_o = entry_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit
// Instruction-fetch stage: PC register, req/ack instruction-memory port and the
// IF/ID pipeline register. Redirects flush wrong-path fetches (including one in
// flight); hazard stalls are absorbed by a one-entry skid buffer.
//
// Optional build macro: FETCH_PERF_CNT_EN adds o_cnt_fetch / o_cnt_flush.
//
// Ports:
//   i_clk         : clock, all state updates on rising edge
//   i_rst_n       : synchronous active-low reset
//   i_stall       : hold PC and IF/ID
//   i_pcsrc       : redirect request (priority over stall and ack)
//   i_nextpc      : redirect target, bits [1:0] ignored
//   o_imem_req    : fetch request valid
//   o_imem_addr   : fetch address (word aligned)
//   i_imem_ack    : memory returns data this cycle
//   i_imem_rdata  : instruction word, valid with i_imem_ack
//   o_cnt_fetch   : (FETCH_PERF_CNT_EN) instructions loaded into IF/ID
//   o_cnt_flush   : (FETCH_PERF_CNT_EN) cycles with i_pcsrc=1
//   o_ifid_instr  : IF/ID instruction
//   o_ifid_pc4    : IF/ID fetch address + 4
//   o_ifid_valid  : IF/ID holds a real instruction
// -----------------------------------------------------------------------------
module fetch_pc_unit
   import fetch_pc_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_C,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
)
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_stall,
   input  logic        i_pcsrc,
   input  logic [31:0] i_nextpc,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_ack,
   input  logic [31:0] i_imem_rdata,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0] o_cnt_fetch,
   output logic [31:0] o_cnt_flush,
`endif
   output logic [31:0] o_ifid_instr,
   output logic [31:0] o_ifid_pc4,
   output logic        o_ifid_valid
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  tgt_q, tgt_d;
   fetch_entry_t ifid_q, ifid_d;
   logic         ifid_valid_q, ifid_valid_d;
   // Set one cycle after reset releases; keeps the port idle in the reset
   // cycle and makes any ack left over from before reset meaningless.
   logic         run_q;

   logic         req;
   logic         ack_ok;
   logic [31:0]  pc_plus4;
   logic [31:0]  redirect_tgt;
   logic         ifid_load;

   logic         skid_load, skid_drain, skid_clear, skid_full;
   fetch_entry_t skid_in, skid_out;

   // -------------------------------------------------------------------------
   // Datapath helpers
   // -------------------------------------------------------------------------
   assign pc_plus4     = pc_q + PC_INC_C;     // wraps modulo 2^32
   assign redirect_tgt = align_pc(i_nextpc);
   assign skid_in      = '{instr: i_imem_rdata, pc4: pc_plus4};

   // Requests depend only on registered state, so the memory sees a stable
   // req/addr for the whole cycle. A full skid blocks new requests.
   assign req    = run_q && !skid_full;
   assign ack_ok = req && i_imem_ack;

   assign o_imem_req  = req;
   assign o_imem_addr = pc_q;                 // frozen at the killed address in KILL

   // -------------------------------------------------------------------------
   // Next-state / control
   // -------------------------------------------------------------------------
   // NOTE: every signal written here gets a default first, so no path through
   // the branches leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      tgt_d        = tgt_q;
      ifid_d       = ifid_q;
      ifid_valid_d = ifid_valid_q;
      skid_load    = 1'b0;
      skid_drain   = 1'b0;
      skid_clear   = 1'b0;
      ifid_load    = 1'b0;

      if (i_pcsrc) begin
         // Redirect: flush IF/ID and skid, drop any same-cycle data.
         ifid_d       = '{instr: NOP_INSTR, pc4: 32'h0};
         ifid_valid_d = 1'b0;
         skid_clear   = 1'b1;
         if (req && !i_imem_ack) begin
            // Request is on the bus and must complete before re-targeting.
            tgt_d   = redirect_tgt;
            state_d = KILL;
         end else begin
            pc_d    = redirect_tgt;
            state_d = FETCH;
         end
      end else begin
         case (state_q)
            KILL: begin
               if (ack_ok) begin
                  pc_d    = tgt_q;
                  state_d = FETCH;
               end
            end
            default: begin  // FETCH, WAIT
               if (skid_full) begin
                  if (!i_stall) begin
                     ifid_d       = skid_out;
                     ifid_valid_d = 1'b1;
                     skid_drain   = 1'b1;
                     ifid_load    = 1'b1;
                  end
               end else if (ack_ok) begin
                  pc_d    = pc_plus4;
                  state_d = FETCH;
                  if (i_stall) begin
                     skid_load = 1'b1;
                  end else begin
                     ifid_d       = skid_in;
                     ifid_valid_d = 1'b1;
                     ifid_load    = 1'b1;
                  end
               end else if (req) begin
                  state_d = WAIT;
               end
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q      <= FETCH;
         pc_q         <= align_pc(RESET_PC);
         tgt_q        <= 32'h0;
         ifid_q       <= '{instr: NOP_INSTR, pc4: 32'h0};
         ifid_valid_q <= 1'b0;
         run_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         tgt_q        <= tgt_d;
         ifid_q       <= ifid_d;
         ifid_valid_q <= ifid_valid_d;
         run_q        <= 1'b1;
      end
   end

   fetch_skid_buf u_skid (
      .clk_i   (i_clk),
      .rst_ni  (i_rst_n),
      .load_i  (skid_load),
      .drain_i (skid_drain),
      .clear_i (skid_clear),
      .entry_i (skid_in),
      .full_o  (skid_full),
      .entry_o (skid_out)
   );

   assign o_ifid_instr = ifid_q.instr;
   assign o_ifid_pc4   = ifid_q.pc4;
   assign o_ifid_valid = ifid_valid_q;

`ifdef FETCH_PERF_CNT_EN
   // -------------------------------------------------------------------------
   // Performance counters (wrap naturally)
   // -------------------------------------------------------------------------
   logic [31:0] cnt_fetch_q;
   logic [31:0] cnt_flush_q;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         cnt_fetch_q <= 32'h0;
         cnt_flush_q <= 32'h0;
      end else begin
         if (ifid_load) cnt_fetch_q <= cnt_fetch_q + 32'd1;
         if (i_pcsrc)   cnt_flush_q <= cnt_flush_q + 32'd1;
      end
   end

   assign o_cnt_fetch = cnt_fetch_q;
   assign o_cnt_flush = cnt_flush_q;
`endif

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch stage and consumer of the branch/jump resolution signals: holds the PC register and drives a req/ack instruction-memory port.
- Loads the IF/ID pipeline register with the fetched instruction and PC+4.
- On redirect (i_pcsrc/i_nextpc from ID-stage next-PC logic) it flushes wrong-path fetches, including one already in flight.
- Honours hazard-unit stalls through a one-entry skid buffer.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0000, instruction word inserted on flush/reset.

Ports:
- i_clk  input  1  clock; all state updates on rising edge
- i_rst_n  input  1  synchronous active-low reset
- i_stall  input  1  hazard unit: hold PC and IF/ID
- i_pcsrc  input  1  redirect request from next-PC logic
- i_nextpc  input  32  redirect target; bits [1:0] ignored
- o_imem_req  output  1  fetch request valid
- o_imem_addr  output  32  fetch address, bits [1:0] always 0
- i_imem_ack  input  1  memory returns data this cycle (may coincide with req)
- i_imem_rdata  input  32  instruction word, valid when i_imem_ack=1
- o_ifid_instr  output  32  IF/ID instruction
- o_ifid_pc4  output  32  IF/ID fetch address + 4 (feeds i_pc of next-PC logic)
- o_ifid_valid  output  1  IF/ID holds a real instruction

Behaviour:
- Reset (i_rst_n=0 at edge), which aborts any outstanding request and discards any later ack:
  - pc=RESET_PC, state=FETCH, skid empty, o_imem_req=0.
  - o_ifid_instr=NOP_INSTR, o_ifid_pc4=0, o_ifid_valid=0.
  - First request is issued in the cycle after reset deasserts.
- Request handshake:
  - o_imem_req=1 with o_imem_addr=pc held stable until i_imem_ack.
  - At most one request outstanding; zero-wait memory (ack in the same cycle as req) gives 1 instruction/cycle.
- States:
  - FETCH: req asserted (unless skid full). ack and no stall → IF/ID<={rdata, pc+4, 1}, pc<=pc+4, stay FETCH. No ack → WAIT.
  - WAIT: req held. Handles ack exactly as in FETCH.
  - KILL: a redirect occurred with a request outstanding and unacked. req=1, address frozen. The next ack's data is discarded, then pc=target and → FETCH.
- Stall (i_stall=1, i_pcsrc=0): pc and IF/ID hold.
  - Ack during stall → data+pc4 captured in skid, pc<=pc+4, req deasserted while skid full.
  - On stall release, IF/ID loads from skid first (skid empties), then normal fetch resumes.
- Redirect (i_pcsrc=1) has priority over stall and ack:
  - IF/ID <= {NOP_INSTR, 0, 0}; skid cleared; same-cycle ack data dropped.
  - No request outstanding → pc<=i_nextpc&~3, state FETCH.
  - Request outstanding and unacked → latch target, state KILL.
  - Redirect while in KILL overwrites the latched target.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC → 0.
- IF/ID changes only on fetch, skid drain, flush or reset; never mid-cycle glitch-driven.

Optional Feature:
- FETCH_PERF_CNT_EN defined:
  - Adds outputs o_cnt_fetch and o_cnt_flush, both 32 bits, cleared on reset.
  - o_cnt_fetch increments per instruction loaded into IF/ID.
  - o_cnt_flush increments per cycle with i_pcsrc=1; both counters wrap.
- Undefined: ports and logic absent.

Decomposition:
- Shared package:
  - state enum FETCH/WAIT/KILL (2-bit).
  - constants NOP_INSTR_C, PC_INC_C=4, RESET_PC_C.
- Sub-module fetch_skid_buf, natural: one-entry {instr, pc4} buffer with load/drain/clear and full flag.
- FSM and PC register live in the top module.

Test Plan:
- Zero-wait memory, ack tied to req, no stall/redirect → IF/ID pc4 sequence 4, 8, 12…; valid=1 from cycle 2 after reset.
- 2-cycle memory latency → req/addr stable across the wait; IF/ID updates every 3rd cycle; no duplicate or skipped addresses.
- Redirect to 32'h0000_0100 while WAIT at addr 0x8 → KILL; the ack with data 0xDEADBEEF never reaches IF/ID; next request addr 0x100; IF/ID valid=0 for the flush cycle.
- Ack arrives during a 3-cycle stall → skid full, req=0; on release IF/ID gets skid data, then fetch continues at +4.
- i_pcsrc and i_stall and ack all in the same cycle, i_nextpc=0x203 → IF/ID flushed, skid cleared, next addr 0x200.
- pc=0xFFFF_FFFC fetch → next addr 0x0, pc4=0x0. Reset asserted during WAIT → the late ack is ignored and fetch restarts at RESET_PC.
